// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared state encoding and default width for the register write arbiter
package reg_arb_pkg;
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;
    localparam int W_DEF = 32;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wraparound
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o
);
    logic          found;
    logic [PW-1:0] j;
    // scan N positions starting at ptr, keep the first requester seen
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                idx_o    = j;
                gnt_o[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin sharing of one register write port with lockable ownership and idle timeout
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N            = 4,
    parameter int W            = W_DEF,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_wdata,
    input  logic [N-1:0]   req_lock,
    output logic [N-1:0]   gnt,
    output logic           reg_wr,
    output logic [W-1:0]   reg_wdata,
    input  logic [W-1:0]   reg_rdata,
    output logic [W-1:0]   rd_data,
    output logic           locked,
    output logic           lock_err
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e    state_q;
    logic [PW-1:0] ptr_q, owner_q, ptr_d, pick_idx, win_idx;
    logic [CW-1:0] idle_q, idle_d;
    logic [N-1:0]  pick_gnt;
    logic          reg_wr_q, lock_err_q, xfer, timeout;
    logic [W-1:0]  reg_wdata_q;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // grant comes from the picker when arbitrating, only the owner may go while locked
    always_comb begin
        gnt     = reset ? '0 : (state_q == ARB) ? pick_gnt
                                                : ({{(N-1){1'b0}}, req[owner_q]} << owner_q);
        win_idx = (state_q == ARB) ? pick_idx : owner_q;
        xfer    = |(req & gnt);
        ptr_d   = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        idle_d  = (idle_q == CW'(LOCK_TIMEOUT)) ? idle_q : idle_q + 1'b1;
        timeout = (state_q == LOCKED) && !req[owner_q] && (idle_d == CW'(LOCK_TIMEOUT));
    end

    // arbitration state, lock ownership, idle counting and the registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            idle_q      <= '0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= '0;
            lock_err_q  <= 1'b0;
        end else begin
            reg_wr_q   <= xfer;
            lock_err_q <= timeout;
            if (xfer)
                reg_wdata_q <= req_wdata[int'(win_idx)*W +: W];
            if (state_q == ARB) begin
                if (xfer) begin
                    ptr_q <= ptr_d;
                    if (req_lock[win_idx]) begin
                        state_q <= LOCKED;
                        owner_q <= win_idx;
                        idle_q  <= '0;
                    end
                end
            end else if (xfer) begin
                idle_q <= '0;
                if (!req_lock[owner_q])
                    state_q <= ARB;
            end else begin
                idle_q <= idle_d;
                if (timeout)
                    state_q <= ARB;
            end
        end
    end

    assign reg_wr    = reg_wr_q;
    assign reg_wdata = reg_wdata_q;
    assign lock_err  = lock_err_q;
    assign locked    = (state_q == LOCKED);
    assign rd_data   = reg_rdata;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vectors with hand-computed expectations for the register write arbiter
module tb_reg_write_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_lock, gnt;
    logic [N*W-1:0] req_wdata;
    logic           reg_wr, locked, lock_err;
    logic [W-1:0]   reg_wdata, reg_rdata, rd_data;
    int             n_run = 0;
    int             n_fail = 0;
    logic [W-1:0]   d [4];

    always #5 clk = ~clk;

    reg_write_arbiter #(.N(N), .W(W), .LOCK_TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_wdata (req_wdata),
        .req_lock  (req_lock),
        .gnt       (gnt),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .rd_data   (rd_data),
        .locked    (locked),
        .lock_err  (lock_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        d[0] = 32'h1234; d[1] = 32'hcdef; d[2] = 32'hbeef; d[3] = 32'h2424;
        reset     = 1'b1;
        req       = 4'b1111;
        req_lock  = 4'b0000;
        req_wdata = {d[3], d[2], d[1], d[0]};
        reg_rdata = 32'h5a5a_0001;
        cyc();
        cyc();
        #1;
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_wr", 64'(reg_wr), 64'h0);
        check("rst_wdata", 64'(reg_wdata), 64'h0);
        check("rst_locked", 64'(locked), 64'h0);
        check("rst_lockerr", 64'(lock_err), 64'h0);
        check("rd_pass0", 64'(rd_data), 64'h5a5a_0001);
        reg_rdata = 32'hc0de_beef;
        #1;
        check("rd_pass1", 64'(rd_data), 64'hc0de_beef);

        // single transfer from client 0
        reset = 1'b0;
        req   = 4'b0001;
        req_wdata[0 +: W] = 32'habcd;
        #1;
        check("single_gnt", 64'(gnt), 64'h1);
        cyc();
        req = 4'b0000;
        #1;
        check("single_wr", 64'(reg_wr), 64'h1);
        check("single_wdata", 64'(reg_wdata), 64'habcd);
        cyc();
        check("single_wr_off", 64'(reg_wr), 64'h0);

        // re-reset so rotation starts at client 0
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        req_wdata = {d[3], d[2], d[1], d[0]};
        req       = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rot_gnt%0d", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                check($sformatf("rot_wr%0d", k), 64'(reg_wr), 64'h1);
                check($sformatf("rot_wdata%0d", k), 64'(reg_wdata), 64'(d[(k - 1) % 4]));
            end
            cyc();
        end
        req = 4'b0000;
        check("rot_last_wdata", 64'(reg_wdata), 64'(d[0]));
        check("rot_last_wr", 64'(reg_wr), 64'h1);

        // pointer is at 1: client 1 alone moves it to 2, then client 2 locks
        req = 4'b0010;
        cyc();
        req      = 4'b0111;
        req_lock = 4'b0100;
        req_wdata[2*W +: W] = 32'h2000;
        #1;
        check("lock_first_gnt", 64'(gnt), 64'h4);
        cyc();
        for (int k = 1; k <= 3; k++) begin
            req_wdata[2*W +: W] = W'(32'h2000 + k);
            req_lock = (k < 3) ? 4'b0100 : 4'b0000;
            #1;
            check($sformatf("lock_locked%0d", k), 64'(locked), 64'h1);
            check($sformatf("lock_gnt%0d", k), 64'(gnt), 64'h4);
            check($sformatf("lock_wdata%0d", k), 64'(reg_wdata), 64'(32'h2000 + k - 1));
            cyc();
        end
        req_lock = 4'b0000;
        req      = 4'b1111;
        #1;
        check("unlock_locked", 64'(locked), 64'h0);
        check("unlock_wdata", 64'(reg_wdata), 64'h2003);
        check("unlock_gnt3", 64'(gnt), 64'h8);
        req = 4'b0011;
        #1;
        check("unlock_gnt0", 64'(gnt), 64'h1);
        req = 4'b0000;
        cyc();

        // pointer is at 3: client 1 locks then goes idle while client 0 waits
        req_wdata = {d[3], d[2], d[1], d[0]};
        req       = 4'b0010;
        req_lock  = 4'b0010;
        #1;
        check("to_lock_gnt", 64'(gnt), 64'h2);
        cyc();
        req      = 4'b0001;
        req_lock = 4'b0000;
        #1;
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("to_locked%0d", k), 64'(locked), 64'h1);
            check($sformatf("to_err%0d", k), 64'(lock_err), 64'h0);
            check($sformatf("to_gnt%0d", k), 64'(gnt), 64'h0);
            cyc();
        end
        check("to_err_pulse", 64'(lock_err), 64'h1);
        check("to_unlocked", 64'(locked), 64'h0);
        check("to_pending_gnt", 64'(gnt), 64'h1);
        cyc();
        req = 4'b0000;
        check("to_err_clear", 64'(lock_err), 64'h0);
        check("to_pending_wr", 64'(reg_wr), 64'h1);
        check("to_pending_wdata", 64'(reg_wdata), 64'(d[0]));

        // reset lands on a handshake cycle
        req      = 4'b0100;
        req_lock = 4'b0100;
        reset    = 1'b1;
        #1;
        check("rsths_gnt", 64'(gnt), 64'h0);
        cyc();
        reset    = 1'b0;
        req_lock = 4'b0000;
        req      = 4'b1111;
        #1;
        check("rsths_wr", 64'(reg_wr), 64'h0);
        check("rsths_wdata", 64'(reg_wdata), 64'h0);
        check("rsths_locked", 64'(locked), 64'h0);
        check("rsths_gnt0", 64'(gnt), 64'h1);
        req = 4'b1010;
        #1;
        check("rsths_gnt1", 64'(gnt), 64'h2);
        req = 4'b0000;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one 32-bit register write port (wr, wdata) between N requesters using round-robin arbitration.
- A requester can lock the register for back-to-back writes. A lock timeout frees a stalled lock.
- Sits between the requester clients and the register instance. Drives the register's wr/wdata and fans its rdata back out to all clients.

Parameters:
- N, 4, number of requesters (2..8)
- W, 32, data width; matches the register
- LOCK_TIMEOUT, 16, idle cycles allowed while locked before a forced release (>=1)

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- req  input  N  request per client
- req_wdata  input  N*W  write data per client; client i uses bits [i*W +: W]
- req_lock  input  N  client i asks to keep ownership after this transfer
- gnt  output  N  one-hot grant, combinational, same cycle as req
- reg_wr  output  1  write strobe to the register (registered)
- reg_wdata  output  W  write data to the register (registered)
- reg_rdata  input  W  register read data
- rd_data  output  W  reg_rdata passed straight through to all clients
- locked  output  1  arbiter is in the LOCKED state
- lock_err  output  1  one-cycle pulse when a lock is force-released by timeout

Behaviour:
- Reset, effective at the edge where reset=1:
  - reg_wr=0, reg_wdata=0, lock_err=0, locked=0.
  - State=ARB, rr pointer=0, owner=0, idle counter=0.
  - gnt forced to 0 in any cycle where reset=1.
  - A reset mid-lock or mid-transfer drops everything; no write is issued from that cycle.
- Handshake:
  - A transfer occurs at the edge where req[i]=1 and gnt[i]=1.
  - At that edge: reg_wr<=1 and reg_wdata<=req_wdata[i]. The register therefore sees the write one cycle after the handshake.
  - reg_wr is 0 in any cycle with no transfer on the previous edge.
  - A client that keeps req high after a transfer is issuing a new request.
  - At most one transfer per cycle. Sustained throughput is one write per cycle.
- State ARB:
  - Winner is the first set bit of req, scanning from the rr pointer upward and wrapping at N-1 to 0.
  - gnt is the one-hot of the winner; gnt=0 if req=0.
  - On a transfer by client i:
    - rr pointer <= (i+1) mod N.
    - If req_lock[i]=1: state<=LOCKED, owner<=i, idle counter<=0.
- State LOCKED (locked=1):
  - gnt[owner]=req[owner]; every other gnt bit is 0. All other requests stall.
  - On an owner transfer with req_lock=0: state<=ARB.
  - On an owner transfer with req_lock=1: stay LOCKED.
  - rr pointer is unchanged while LOCKED; it stays at owner+1 from the locking transfer.
  - Idle counter:
    - Cleared on every owner transfer.
    - Increments in each cycle where req[owner]=0.
    - When the counter reaches LOCK_TIMEOUT: state<=ARB and lock_err=1 for exactly one cycle.
    - No transfer is granted in the cycle the counter reaches LOCK_TIMEOUT.
- rd_data:
  - Combinational passthrough of reg_rdata.
  - Because of the register's same-cycle read/write behaviour, clients see new data per the register's own contract.
  - The arbiter adds no read latency.
- Simultaneous events:
  - Reset overrides timeout and transfers.
  - A timeout and an owner request cannot both occur, since the timeout requires req[owner]=0.
- Counter width: clog2(LOCK_TIMEOUT+1). It saturates; it never wraps.

Decomposition:
- Shared package reg_arb_pkg holds:
  - State encoding ARB=1'b0, LOCKED=1'b1.
  - Default width constant W_DEF=32.
- One natural sub-module: rr_pick.
  - Purely combinational.
  - Inputs: req[N], ptr; outputs: one-hot gnt and binary index.
  - Reusable by other arbiters in the design.

Test Plan:
- Reset then req=4'b0001, data0=32'habcd for 1 cycle:
  - gnt=0001 that cycle.
  - Next cycle reg_wr=1, reg_wdata=32'habcd.
  - Following cycle reg_wr=0.
- All 4 clients request continuously with data 32'h1234/32'hcdef/32'hbeef/32'h2424:
  - Grants rotate 0,1,2,3,0 on consecutive cycles.
  - reg_wdata follows the same order one cycle behind.
  - reg_wr held at 1.
- Client 2 transfers with req_lock=1 while clients 0 and 1 request:
  - locked=1, and only client 2 is granted for 3 locked writes.
  - On its req_lock=0 transfer, state returns to ARB and client 3 wins if requesting, else client 0.
- Client 1 locks, then drops req:
  - After 16 idle cycles, lock_err pulses for 1 cycle and locked=0.
  - Pending client 0 is granted on the next cycle.
- Reset asserted in the same cycle as a handshake:
  - gnt=0, and the next cycle reg_wr=0, reg_wdata=0, locked=0.
  - After release, arbitration starts from client 0.
